// File: rtl/cache_set_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with a tree pseudo-LRU
// victim choice and an IDLE/WB/REFILL miss engine in front of a block-wide memory.
module cache_set_assoc #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter int INDEX_WIDTH        = 4,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int WAYS               = 2,
  parameter int CNT_WIDTH          = 32,
  parameter int BLOCK_SIZE         = 1 << BLOCK_OFFSET_WIDTH,
  parameter int TAG_WIDTH          = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             req,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic                             ready,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] mem_wdata,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] mem_rdata,
  input  logic                             mem_ready,
  output logic [CNT_WIDTH-1:0]             hit_count,
  output logic [CNT_WIDTH-1:0]             miss_count,
  output logic [1:0]                       dbg_state
);

  localparam int SETS    = 1 << INDEX_WIDTH;
  localparam int BLOCK_W = DATA_WIDTH * BLOCK_SIZE;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  // PLRU tree kept in heap order (root at bit 0); width padded to at least 2 so
  // every variable bit-select has a clean index width. Bit WAYS-1 stays 0.
  localparam int PLRU_W  = (WAYS < 2) ? 2 : WAYS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_REFILL = 2'd2} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [SETS-1:0][WAYS-1:0]   dirty_q;
  logic [SETS-1:0][PLRU_W-1:0] plru_q;
  logic [TAG_WIDTH-1:0]        tag_q  [SETS][WAYS];
  logic [BLOCK_W-1:0]          data_q [SETS][WAYS];

  logic [WAY_W-1:0] victim_q;
  logic             retry_q;

  logic [TAG_WIDTH-1:0]          req_tag;
  logic [INDEX_WIDTH-1:0]        req_idx;
  logic [BLOCK_OFFSET_WIDTH-1:0] req_off;
  logic [WAYS-1:0]               hit_vec;
  logic [WAY_W-1:0]              hit_way;
  logic [WAY_W-1:0]              inv_way;
  logic                          inv_found;
  logic [WAY_W-1:0]              victim_way;
  logic [DATA_WIDTH-1:0]         hit_word;

  assign req_tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx = addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_off = addr[BLOCK_OFFSET_WIDTH-1:0];

  // Walk the tree from the root: each node bit names the subtree to evict from.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    logic [WAY_W-1:0] v;
    int node;
    v = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      if (WAYS > 1) begin
        v[WAY_W-1-l] = p[WAY_W'(node)];
        node = 2 * node + 1 + int'(p[WAY_W'(node)]);
      end
    end
    return v;
  endfunction

  // Point every node on the path to way w away from it, making w most recent.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0] w);
    logic [PLRU_W-1:0] r;
    int node;
    r = p;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      if (WAYS > 1) begin
        r[WAY_W'(node)] = ~w[WAY_W-1-l];
        node = 2 * node + 1 + int'(w[WAY_W-1-l]);
      end
    end
    return r;
  endfunction

  always_comb begin
    hit_vec   = '0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
    hit_word   = data_q[req_idx][hit_way][int'(req_off) * DATA_WIDTH +: DATA_WIDTH];
  end

  assign hit       = req & (|hit_vec);
  assign dout      = hit ? hit_word : '0;
  assign ready     = (state_q == S_IDLE) & (~req | hit);
  assign dbg_state = state_q;

  // Handshake: mem_req/mem_we/mem_addr/mem_wdata are held from state entry until
  // the single-cycle mem_ready pulse; mem_ready outside WB/REFILL is ignored.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way])
                    ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
        mem_wdata = data_q[req_idx][victim_q];
        if (mem_ready) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      retry_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      plru_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          retry_q <= 1'b0;
          if (hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            if (we) dirty_q[req_idx][hit_way] <= 1'b1;
            // The access replayed after a refill was already counted as a miss.
            if (!retry_q && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
          end else if (req) begin
            victim_q <= victim_way;
            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            retry_q                    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; validity alone decides their meaning.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && hit && we) begin
      data_q[req_idx][hit_way][int'(req_off) * DATA_WIDTH +: DATA_WIDTH] <= din;
    end
    if (state_q == S_REFILL && mem_ready) begin
      data_q[req_idx][victim_q] <= mem_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc: a 2-way instance driven from a vector table
// against a behavioural block memory, plus reset-abort and direct-mapped sequences.
module tb_cache_set_assoc;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req, we;
  logic [9:0]   addr;
  logic [31:0]  din, dout;
  logic         ready, hit;
  logic         mem_req, mem_we, mem_ready;
  logic [9:0]   mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic [31:0]  hit_count, miss_count;
  logic [1:0]   dbg_state;

  logic         w1_req;
  logic [9:0]   w1_addr;
  logic [31:0]  w1_dout;
  logic         w1_ready, w1_hit;
  logic         w1_mem_req, w1_mem_we, w1_mem_ready;
  logic [9:0]   w1_mem_addr;
  logic [255:0] w1_mem_wdata, w1_mem_rdata;
  logic [31:0]  w1_hit_count, w1_miss_count;
  logic [1:0]   w1_dbg_state;

  cache_set_assoc #(.WAYS(2)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .din(din),
    .ready(ready), .hit(hit), .dout(dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  cache_set_assoc #(.WAYS(1)) u_dut_w1 (
    .clk(clk), .rstn(rstn), .req(w1_req), .we(1'b0), .addr(w1_addr), .din(32'h0),
    .ready(w1_ready), .hit(w1_hit), .dout(w1_dout),
    .mem_req(w1_mem_req), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
    .hit_count(w1_hit_count), .miss_count(w1_miss_count), .dbg_state(w1_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [1024];
  int lat = 3;
  int wcnt = 0;
  int wb_cnt = 0;
  int rf_cnt = 0;
  logic [9:0]   wb_addr, rf_addr;
  logic [255:0] wb_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Block memory for the 2-way instance: mem_ready pulses after lat waiting cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      if (!mem_req) begin
        wcnt = 0;
      end else if (wcnt == lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          wb_cnt++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
          for (int k = 0; k < 8; k++) mem[int'(mem_addr) + k] = mem_wdata[k*32 +: 32];
        end else begin
          rf_cnt++;
          rf_addr = mem_addr;
          for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = mem[int'(mem_addr) + k];
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Zero-latency read-only memory for the direct-mapped instance.
  initial begin
    w1_mem_ready = 1'b0;
    w1_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (w1_mem_ready) begin
        w1_mem_ready = 1'b0;
      end else if (w1_mem_req) begin
        for (int k = 0; k < 8; k++) w1_mem_rdata[k*32 +: 32] = mem[int'(w1_mem_addr) + k];
        w1_mem_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic w, input logic [9:0] a, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; din = d; cyc = 0;
    #1;
    while (!ready && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    rd = dout;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_access_w1(input logic [9:0] a, output int cyc, output logic [31:0] rd);
    @(negedge clk);
    w1_req = 1'b1; w1_addr = a; cyc = 0;
    #1;
    while (!w1_ready && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    rd = w1_dout;
    @(posedge clk); #1;
    w1_req = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    int          lat;
    logic [31:0] e_dout;
    int          e_cyc;
    logic        e_wb;
    logic [9:0]  e_wb_addr;
    int          e_wb_off;
    logic [31:0] e_wb_word;
    logic [9:0]  e_rf_addr;
    logic [31:0] e_hits;
    logic [31:0] e_miss;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int cyc;
    logic [31:0] rd;
    int pre_wb, pre_rf;
    logic [31:0] exp_q [$];

    // w, addr, din, lat, dout, cycles, wb, wb_addr, wb_off, wb_word, rf_addr, hits, misses
    vecs[0]  = '{1'b0, 10'h013, 32'h0,        3, 32'hDEADBEEF, 5, 1'b0, 10'h0,   0, 32'h0,        10'h010, 0, 1};
    vecs[1]  = '{1'b1, 10'h013, 32'h55,       3, 32'hDEADBEEF, 0, 1'b0, 10'h0,   0, 32'h0,        10'h0,   1, 1};
    vecs[2]  = '{1'b0, 10'h013, 32'h0,        3, 32'h00000055, 0, 1'b0, 10'h0,   0, 32'h0,        10'h0,   2, 1};
    vecs[3]  = '{1'b0, 10'h010, 32'h0,        3, 32'hA5000010, 0, 1'b0, 10'h0,   0, 32'h0,        10'h0,   3, 1};
    vecs[4]  = '{1'b1, 10'h110, 32'h12345678, 2, 32'hA5000110, 4, 1'b0, 10'h0,   0, 32'h0,        10'h110, 3, 2};
    vecs[5]  = '{1'b0, 10'h010, 32'h0,        2, 32'hA5000010, 0, 1'b0, 10'h0,   0, 32'h0,        10'h0,   4, 2};
    vecs[6]  = '{1'b0, 10'h210, 32'h0,        2, 32'hA5000210, 7, 1'b1, 10'h110, 0, 32'h12345678, 10'h210, 4, 3};
    vecs[7]  = '{1'b0, 10'h028, 32'h0,        1, 32'hA5000028, 3, 1'b0, 10'h0,   0, 32'h0,        10'h028, 4, 4};
    vecs[8]  = '{1'b0, 10'h128, 32'h0,        1, 32'hA5000128, 3, 1'b0, 10'h0,   0, 32'h0,        10'h128, 4, 5};
    vecs[9]  = '{1'b0, 10'h028, 32'h0,        1, 32'hA5000028, 0, 1'b0, 10'h0,   0, 32'h0,        10'h0,   5, 5};
    vecs[10] = '{1'b0, 10'h228, 32'h0,        1, 32'hA5000228, 3, 1'b0, 10'h0,   0, 32'h0,        10'h228, 5, 6};
    vecs[11] = '{1'b0, 10'h110, 32'h0,        1, 32'h12345678, 5, 1'b1, 10'h010, 3, 32'h00000055, 10'h110, 5, 7};
    vecs[12] = '{1'b0, 10'h013, 32'h0,        0, 32'h00000055, 2, 1'b0, 10'h0,   0, 32'h0,        10'h010, 5, 8};

    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[10'h013] = 32'hDEADBEEF;

    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; din = '0;
    w1_req = 1'b0; w1_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    check("rst mem_addr", {22'b0, mem_addr}, 32'd0);
    check("rst mem_wdata", {31'b0, |mem_wdata}, 32'd0);
    check("rst ready idle", {31'b0, ready}, 32'd1);
    check("rst state", {30'b0, dbg_state}, 32'd0);
    check("rst hit_count", hit_count, 32'd0);
    check("rst miss_count", miss_count, 32'd0);
    req = 1'b1; addr = 10'h013;
    #1;
    check("rst ready req", {31'b0, ready}, 32'd0);
    check("rst hit", {31'b0, hit}, 32'd0);
    check("rst dout", dout, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      lat = vecs[i].lat;
      pre_wb = wb_cnt;
      pre_rf = rf_cnt;
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, cyc, rd);
      check($sformatf("v%0d dout", i), rd, vecs[i].e_dout);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].e_cyc);
      check($sformatf("v%0d hit_count", i), hit_count, vecs[i].e_hits);
      check($sformatf("v%0d miss_count", i), miss_count, vecs[i].e_miss);
      check($sformatf("v%0d writebacks", i), wb_cnt - pre_wb, {31'b0, vecs[i].e_wb});
      check($sformatf("v%0d refills", i), rf_cnt - pre_rf, (vecs[i].e_cyc > 0) ? 32'd1 : 32'd0);
      if (vecs[i].e_wb) begin
        check($sformatf("v%0d wb addr", i), {22'b0, wb_addr}, {22'b0, vecs[i].e_wb_addr});
        check($sformatf("v%0d wb word", i), wb_data[vecs[i].e_wb_off*32 +: 32], vecs[i].e_wb_word);
      end
      if (vecs[i].e_cyc > 0) begin
        check($sformatf("v%0d rf addr", i), {22'b0, rf_addr}, {22'b0, vecs[i].e_rf_addr});
      end
    end

    // Reset while a refill is outstanding: the request must drop asynchronously.
    lat = 1000;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h300;
    repeat (3) @(negedge clk);
    #1;
    check("abort mem_req before", {31'b0, mem_req}, 32'd1);
    check("abort mem_addr", {22'b0, mem_addr}, 32'h300);
    check("abort mem_we", {31'b0, mem_we}, 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("abort mem_req after", {31'b0, mem_req}, 32'd0);
    check("abort ready", {31'b0, ready}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort hit_count", hit_count, 32'd0);
    check("abort miss_count", miss_count, 32'd0);

    // 0x013 was cached before reset, so it must miss now; refill brings the written-back 0x55.
    exp_q.push_back(32'h00000055);
    exp_q.push_back(32'hA5000300);
    lat = 2;
    do_access(1'b0, 10'h013, 32'h0, cyc, rd);
    check("post-rst 013 dout", rd, exp_q.pop_front());
    check("post-rst 013 cycles", cyc, 32'd4);
    check("post-rst miss_count 1", miss_count, 32'd1);
    lat = 1;
    do_access(1'b0, 10'h300, 32'h0, cyc, rd);
    check("post-rst 300 dout", rd, exp_q.pop_front());
    check("post-rst 300 cycles", cyc, 32'd3);
    check("post-rst miss_count 2", miss_count, 32'd2);
    check("post-rst hit_count", hit_count, 32'd0);

    // Direct-mapped instance: two tags in set 7 keep evicting each other.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back((i % 2 == 0) ? 32'hA5000038 : 32'hA50000B8);
      do_access_w1((i % 2 == 0) ? 10'h038 : 10'h0B8, cyc, rd);
      check($sformatf("w1 a%0d dout", i), rd, exp_q.pop_front());
      check($sformatf("w1 a%0d cycles", i), cyc, 32'd2);
    end
    check("w1 hit_count", w1_hit_count, 32'd0);
    check("w1 miss_count", w1_miss_count, 32'd6);
    check("w1 mem_we", {31'b0, w1_mem_we}, 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
